// File: rtl/sram_fifo_ctrl_64x4_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_fifo_pkg
// Brief    : Shared sizing constants and types for the 64x4 SRAM FIFO
//            controller.
// Revision : 1.0 - initial release
// ============================================================================
package sram_fifo_pkg;

  localparam int ADDR_W    = 6;
  localparam int DATA_W    = 4;
  localparam int SKID_D    = 2;
  localparam int CNT_W     = ADDR_W + 1;
  localparam int MEM_DEPTH = 64;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [CNT_W-1:0]  cnt_t;

endpackage
`default_nettype wire

// File: rtl/sram_fifo_ctrl_64x4_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_fifo_stream_if / sram_fifo_mem_if
// Brief    : Stream-side push/pop handshake bundle and the dual-port SRAM
//            macro bus driven by the FIFO controller.
// Revision : 1.0 - initial release
// ============================================================================
interface sram_fifo_stream_if;
  import sram_fifo_pkg::*;

  logic  in_valid;
  logic  in_ready;
  data_t in_data;
  logic  out_valid;
  logic  out_ready;
  data_t out_data;
  cnt_t  count;

  // FIFO side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );

  // Producer/consumer side
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );
endinterface

interface sram_fifo_mem_if;
  import sram_fifo_pkg::*;

  addr_t mem_A0;
  data_t mem_D0;
  logic  mem_WE0;
  logic  mem_CE0;
  data_t mem_WEM0;
  addr_t mem_A1;
  data_t mem_D1;
  logic  mem_WE1;
  logic  mem_CE1;
  data_t mem_WEM1;
  data_t mem_Q1;

  // Controller side
  modport master (
    output mem_A0, mem_D0, mem_WE0, mem_CE0, mem_WEM0,
    output mem_A1, mem_D1, mem_WE1, mem_CE1, mem_WEM1,
    input  mem_Q1
  );

  // SRAM macro side
  modport slave (
    input  mem_A0, mem_D0, mem_WE0, mem_CE0, mem_WEM0,
    input  mem_A1, mem_D1, mem_WE1, mem_CE1, mem_WEM1,
    output mem_Q1
  );
endinterface
`default_nettype wire

// File: rtl/sram_fifo_ctrl_64x4_skid2.sv
`default_nettype none
// ============================================================================
// Module   : sram_fifo_skid2
// Brief    : Two-entry FIFO-ordered output buffer. Entry 0 is always the head;
//            entry 1 holds the next item when both are occupied. The head
//            register keeps its last value when the buffer drains.
// Revision : 1.0 - initial release
// ============================================================================
module sram_fifo_skid2
  import sram_fifo_pkg::*;
(
  input  wire logic  CLK,
  input  wire logic  RSTN,
  input  wire logic  i_push,
  input  wire data_t i_data,
  input  wire logic  i_pop,
  output data_t      o_head,
  output logic [1:0] o_cnt
);

  localparam logic [1:0] c_FULL = 2'(SKID_D);

  data_t      r_d0;
  data_t      r_d1;
  logic [1:0] r_cnt;

  // Shift-style update: pops promote entry 1 to the head, pushes land at the tail
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_d0  <= '0;
      r_d1  <= '0;
      r_cnt <= 2'd0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_d0 <= i_data;
          else               r_d1 <= i_data;
          if (r_cnt != c_FULL) r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          if (r_cnt == c_FULL) r_d0 <= r_d1;
          r_cnt <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == c_FULL) begin
            r_d0 <= r_d1;
            r_d1 <= i_data;
          end else begin
            r_d0 <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_head = r_d0;
  assign o_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: rtl/sram_fifo_ctrl_64x4.sv
`default_nettype none
// ============================================================================
// Module   : sram_fifo_ctrl_64x4
// Brief    : Streaming FIFO controller over a dual-port 64x4 SRAM. Port 0 only
//            writes, port 1 only reads; the 1-cycle read latency is hidden by
//            a 2-entry skid buffer so a ready consumer sees one item per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module sram_fifo_ctrl_64x4
  import sram_fifo_pkg::*;
(
  input  wire logic       CLK,
  input  wire logic       RSTN,
  sram_fifo_stream_if.slave strm,
  sram_fifo_mem_if.master   mem
);

  addr_t      r_wr_ptr;
  addr_t      r_rd_ptr;
  cnt_t       r_mem_cnt;
  logic       r_inflight;

  logic       w_in_ready;
  logic       w_push;
  logic       w_out_valid;
  logic       w_pop;
  logic       w_rd_issue;
  logic [1:0] w_skid_cnt;
  data_t      w_head;

  assign w_in_ready  = RSTN & (r_mem_cnt != cnt_t'(MEM_DEPTH));
  assign w_push      = strm.in_valid & w_in_ready;
  assign w_out_valid = (w_skid_cnt != 2'd0);
  assign w_pop       = w_out_valid & strm.out_ready;

  // Issue a read only if its result is guaranteed a skid slot when it lands,
  // counting the slot a same-cycle pop frees up.
  assign w_rd_issue  = RSTN & (r_mem_cnt != '0) &
                       (({1'b0, w_skid_cnt} + {2'b00, r_inflight}) <
                        (3'd2 + {2'b00, w_pop}));

  // Pointer, occupancy and in-flight tracking; reset drops any pending read
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_mem_cnt  <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_wr_ptr   <= r_wr_ptr + addr_t'(w_push);
      r_rd_ptr   <= r_rd_ptr + addr_t'(w_rd_issue);
      r_mem_cnt  <= r_mem_cnt + cnt_t'(w_push) - cnt_t'(w_rd_issue);
      r_inflight <= w_rd_issue;
    end
  end

  sram_fifo_skid2 u_skid (
    .CLK    (CLK),
    .RSTN   (RSTN),
    .i_push (r_inflight),
    .i_data (mem.mem_Q1),
    .i_pop  (w_pop),
    .o_head (w_head),
    .o_cnt  (w_skid_cnt)
  );

  // Stream side
  assign strm.in_ready  = w_in_ready;
  assign strm.out_valid = w_out_valid;
  assign strm.out_data  = w_head;
  assign strm.count     = r_mem_cnt + cnt_t'(w_skid_cnt) + cnt_t'(r_inflight);

  // SRAM port 0: write only. Address/data are held at zero during reset.
  assign mem.mem_A0   = RSTN ? r_wr_ptr : '0;
  assign mem.mem_D0   = RSTN ? strm.in_data : '0;
  assign mem.mem_WE0  = 1'b1;
  assign mem.mem_CE0  = w_push;
  assign mem.mem_WEM0 = '1;

  // SRAM port 1: read only
  assign mem.mem_A1   = RSTN ? r_rd_ptr : '0;
  assign mem.mem_D1   = '0;
  assign mem.mem_WE1  = 1'b0;
  assign mem.mem_CE1  = w_rd_issue;
  assign mem.mem_WEM1 = '1;

endmodule
`default_nettype wire
